// File: rtl/l2_writeback_buffer.sv
// Writeback queue for evicted dirty L2 lines: holds up to DEPTH lines, drains
// each as a fixed-length memory write burst and serves address lookups.
module l2_writeback_buffer #(
  parameter int s_offset = 5,
  parameter int s_burst  = 64,
  parameter int s_addr   = 32,
  parameter int DEPTH    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wb_valid,
  output logic                          wb_ready,
  input  logic [s_addr-1:0]             wb_addr,
  input  logic [8*(2**s_offset)-1:0]    wb_line,
  input  logic [s_addr-1:0]             lookup_addr,
  output logic                          lookup_hit,
  output logic [8*(2**s_offset)-1:0]    lookup_line,
  output logic                          mem_write,
  output logic [s_addr-1:0]             mem_address,
  output logic [s_burst-1:0]            mem_wdata,
  input  logic                          mem_resp
);

  localparam int s_line = 8 * (2 ** s_offset);
  localparam int BEATS  = s_line / s_burst;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [s_addr-1:0] OFF_MASK = s_addr'((64'd1 << s_offset) - 64'd1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    head_q, head_d;
  logic [PTR_W-1:0]    tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [s_addr-1:0]   mem_address_q, mem_address_d;
  logic [s_burst-1:0]  mem_wdata_q, mem_wdata_d;
  logic [s_addr-1:0]   addr_q [DEPTH];
  logic [s_addr-1:0]   addr_d [DEPTH];
  logic [s_line-1:0]   line_q [DEPTH];
  logic [s_line-1:0]   line_d [DEPTH];

  logic                push;
  logic                pop;
  logic [BEAT_W-1:0]   next_beat;
  logic [PTR_W-1:0]    lk_idx;

  assign wb_ready    = (count_q != CNT_W'(DEPTH));
  assign push        = wb_valid && wb_ready;
  assign pop         = (state_q == BURST) && mem_resp && (beat_q == BEAT_W'(BEATS - 1));
  assign next_beat   = beat_q + 1'b1;
  assign mem_write   = (state_q == BURST);
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;

  // Burst sequencer; address/data registers load ahead of the beat they drive.
  always_comb begin
    state_d       = state_q;
    head_d        = head_q;
    beat_d        = beat_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d       = BURST;
          beat_d        = '0;
          mem_address_d = addr_q[head_q];
          mem_wdata_d   = line_q[head_q][0 +: s_burst];
        end
      end
      BURST: begin
        if (pop) begin
          state_d = IDLE;
          beat_d  = '0;
          head_d  = head_q + 1'b1;
        end else if (mem_resp) begin
          beat_d      = next_beat;
          mem_wdata_d = line_q[head_q][s_burst*next_beat +: s_burst];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tail_d  = tail_q;
    count_d = count_q;
    addr_d  = addr_q;
    line_d  = line_q;
    if (push) begin
      addr_d[tail_q] = wb_addr & ~OFF_MASK;
      line_d[tail_q] = wb_line;
      tail_d         = tail_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_line = '0;
    lk_idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[lk_idx] == (lookup_addr & ~OFF_MASK))) begin
        lookup_hit  = 1'b1;
        lookup_line = line_q[lk_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      beat_q        <= '0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      beat_q        <= beat_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  // Entry storage is qualified by count, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    line_q <= line_d;
  end

endmodule
